// File: rtl/imm_encoder.sv
// Two-stage elastic RISC-V instruction encoder: packs opcode, register/function
// fields and an immediate into a 32-bit word and flags unrepresentable immediates.
module imm_encoder (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_format,
  input  logic [31:0] i_imm,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [6:0]  i_funct7,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [15:0] o_count,
  output logic [7:0]  o_err_count
);

  localparam logic [2:0] FMT_I     = 3'b000;
  localparam logic [2:0] FMT_SHAMT = 3'b001;
  localparam logic [2:0] FMT_S     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_J     = 3'b100;
  localparam logic [2:0] FMT_U     = 3'b101;

  // Handshake: a transfer happens on a side exactly when its valid and ready
  // are both high at a rising edge; valid never waits on ready, and a stage
  // holds its payload stable until its own output transfer completes.
  logic        s1_valid;
  logic [2:0]  s1_format;
  logic [31:0] s1_imm;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [2:0]  s1_funct3;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [6:0]  s1_funct7;

  logic        s1_en;
  logic        s2_en;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        out_fire;

  assign s2_en    = !o_valid || i_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign o_ready  = s1_en;
  assign out_fire = o_valid && i_ready;

  // Sign-extension checks: the bits above the format's top immediate bit must
  // all copy that bit.
  logic i_range_ok;
  logic b_range_ok;
  logic j_range_ok;

  assign i_range_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign b_range_ok = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
  assign j_range_ok = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];

  always_comb begin
    enc_instr = 32'd0;
    enc_err   = 1'b0;
    case (s1_format)
      FMT_SHAMT: begin
        enc_instr = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_err   = |s1_imm[31:5];
      end
      FMT_S: begin
        enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_err   = !i_range_ok;
      end
      FMT_B: begin
        enc_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                     s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_err   = !b_range_ok;
      end
      FMT_J: begin
        enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                     s1_rd, s1_opcode};
        enc_err   = !j_range_ok;
      end
      FMT_U: begin
        enc_instr = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_err   = |s1_imm[11:0];
      end
      default: begin
        // FMT_I and the two unused codes share the I layout.
        enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_err   = !i_range_ok;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_valid  <= 1'b0;
      s1_format <= 3'd0;
      s1_imm    <= 32'd0;
      s1_opcode <= 7'd0;
      s1_rd     <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct7 <= 7'd0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_format <= i_format;
        s1_imm    <= i_imm;
        s1_opcode <= i_opcode;
        s1_rd     <= i_rd;
        s1_funct3 <= i_funct3;
        s1_rs1    <= i_rs1;
        s1_rs2    <= i_rs2;
        s1_funct7 <= i_funct7;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_instr <= 32'd0;
      o_err   <= 1'b0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_instr <= enc_instr;
        o_err   <= enc_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count     <= 16'd0;
      o_err_count <= 8'd0;
    end else if (out_fire) begin
      o_count <= o_count + 16'd1;
      if (o_err && (o_err_count != 8'hFF)) begin
        o_err_count <= o_err_count + 8'd1;
      end
    end
  end

endmodule
